// File: rtl/pokeball_sprite_fetch.sv
// pokeball_sprite_fetch
//   Per-pixel fetch path for the Poke Ball sprite. It hit-tests the beam
//   position against a frame-latched sprite rectangle, addresses a sprite-
//   sheet ROM holding four animation steps, and forwards the returned palette
//   index with a transparency-qualified valid. A small FSM steps the sprite
//   through a 4-step wobble animation, advancing only on frame boundaries.
//
// Ports
//   Clk           in   1   single clock, rising edge
//   Reset_n       in   1   asynchronous active-low reset
//   DrawX/DrawY   in  10   current beam column / row
//   frame_start   in   1   one-cycle pulse at the start of each video frame
//   ball_x/ball_y in  10   sprite top-left corner, latched on frame_start
//   ball_show     in   1   sprite enable, latched on frame_start
//   wobble_start  in   1   request to start the wobble animation
//   rom_addr      out 12   sprite-sheet address {step, row, col}
//   rom_data      in   8   ROM palette index for the previous rom_addr
//   pal_index     out  8   palette index to the palette lookup stage
//   pal_valid     out  1   pal_index is an opaque sprite pixel
//   busy          out  1   wobble animation in progress
module pokeball_sprite_fetch #(
  parameter int         SPRITE_W  = 32,
  parameter int         SPRITE_H  = 32,
  parameter int         HOLD      = 8,
  parameter int         LOOPS     = 3,
  parameter logic [7:0] KEY_INDEX = 8'h00
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        frame_start,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic        ball_show,
  input  logic        wobble_start,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [7:0]  pal_index,
  output logic        pal_valid,
  output logic        busy
);

  localparam int COL_W  = $clog2(SPRITE_W);
  localparam int ROW_W  = $clog2(SPRITE_H);
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int LOOP_W = $clog2(LOOPS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WOBBLE,
    S_SETTLE
  } state_t;

  // Frame-latched sprite placement
  logic [9:0] r_bx_s;
  logic [9:0] r_by_s;
  logic       r_show_s;

  // Animation state
  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_step;
  logic [1:0]         w_step_nxt;
  logic [HOLD_W-1:0]  r_hold;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [LOOP_W-1:0]  r_loop;
  logic [LOOP_W-1:0]  w_loop_nxt;

  // Pipeline
  logic              r_vld_p1;
  logic [11:0]       r_addr_p1;
  logic [7:0]        r_idx_p2;
  logic              r_vld_p2;

  logic [10:0]       w_x;
  logic [10:0]       w_y;
  logic [10:0]       w_bx;
  logic [10:0]       w_by;
  logic              w_hit;
  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;

  // Shadow placement registers: mid-frame changes to ball_* are invisible
  // until the next frame boundary, so a frame never tears.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_bx_s   <= '0;
      r_by_s   <= '0;
      r_show_s <= 1'b0;
    end else if (frame_start) begin
      r_bx_s   <= ball_x;
      r_by_s   <= ball_y;
      r_show_s <= ball_show;
    end
  end

  // Hit test at 11 bits so a sprite placed near column/row 1023 does not
  // wrap its right/bottom edge back to small coordinates.
  assign w_x   = {1'b0, DrawX};
  assign w_y   = {1'b0, DrawY};
  assign w_bx  = {1'b0, r_bx_s};
  assign w_by  = {1'b0, r_by_s};
  assign w_hit = r_show_s
               && (w_x >= w_bx) && (w_x < (w_bx + 11'(SPRITE_W)))
               && (w_y >= w_by) && (w_y < (w_by + 11'(SPRITE_H)));

  assign w_col = COL_W'(DrawX - r_bx_s);
  assign w_row = ROW_W'(DrawY - r_by_s);

  // ---- stage 1: ROM address and hit flag ----
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_addr_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_addr_p1 <= w_hit ? {r_step, w_row, w_col} : '0;
      r_vld_p1  <= w_hit;
    end
  end

  // ---- stage 2: palette index, transparency key applied ----
  // rom_data answers the stage-1 address within the same cycle, so it lines
  // up with r_vld_p1 here, giving two cycles from DrawX/DrawY to pal_*.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_idx_p2 <= '0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_idx_p2 <= r_vld_p1 ? rom_data : '0;
      r_vld_p2 <= r_vld_p1 && (rom_data != KEY_INDEX);
    end
  end

  assign rom_addr  = r_addr_p1;
  assign pal_index = r_idx_p2;
  assign pal_valid = r_vld_p2;

  // Animation FSM: state and counters
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_hold  <= '0;
      r_loop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_hold  <= w_hold_nxt;
      r_loop  <= w_loop_nxt;
    end
  end

  // Counters move only on frame_start while animating, so the step seen by
  // the address path is constant across a whole frame. wobble_start is only
  // honoured in IDLE; a coincident frame_start is not counted.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_hold_nxt  = r_hold;
    w_loop_nxt  = r_loop;
    case (r_state)
      S_IDLE: begin
        w_step_nxt = '0;
        if (wobble_start) begin
          w_state_nxt = S_WOBBLE;
          w_hold_nxt  = '0;
          w_loop_nxt  = '0;
        end
      end
      S_WOBBLE: begin
        if (frame_start) begin
          if (r_hold == HOLD_W'(HOLD - 1)) begin
            w_hold_nxt = '0;
            w_step_nxt = r_step + 2'd1;
            if (r_step == 2'd3) begin
              w_loop_nxt = r_loop + LOOP_W'(1);
              if (r_loop == LOOP_W'(LOOPS - 1)) begin
                w_state_nxt = S_SETTLE;
                w_step_nxt  = '0;
              end
            end
          end else begin
            w_hold_nxt = r_hold + HOLD_W'(1);
          end
        end
      end
      S_SETTLE: begin
        w_step_nxt = '0;
        if (frame_start) begin
          w_state_nxt = S_IDLE;
          w_hold_nxt  = '0;
          w_loop_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_step_nxt  = '0;
        w_hold_nxt  = '0;
        w_loop_nxt  = '0;
      end
    endcase
  end

  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_pokeball_sprite_fetch.sv
module tb_pokeball_sprite_fetch;

  localparam int SW    = 32;
  localparam int SH    = 32;
  localparam int HOLD  = 8;
  localparam int LOOPS = 3;
  localparam int WOBBLE_FRAMES = HOLD * 4 * LOOPS;

  logic        Clk;
  logic        Reset_n;
  logic [9:0]  DrawX, DrawY, ball_x, ball_y;
  logic        frame_start, ball_show, wobble_start;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data, pal_index;
  logic        pal_valid, busy;

  pokeball_sprite_fetch #(
    .SPRITE_W(SW), .SPRITE_H(SH), .HOLD(HOLD), .LOOPS(LOOPS), .KEY_INDEX(8'h00)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .ball_x(ball_x), .ball_y(ball_y),
    .ball_show(ball_show), .wobble_start(wobble_start),
    .rom_addr(rom_addr), .rom_data(rom_data), .pal_index(pal_index),
    .pal_valid(pal_valid), .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Sprite-sheet ROM, asynchronous read. Address 0 holds 2; any address with
  // low bits 5 is transparent; everything else is opaque (bit 7 set).
  function automatic logic [7:0] rom_f(input logic [11:0] a);
    if (a == 12'h000) return 8'h02;
    if (a[2:0] == 3'd5) return 8'h00;
    return (a[7:0] ^ {2'b00, a[11:6]}) | 8'h80;
  endfunction
  assign rom_data = rom_f(rom_addr);

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int due; logic [11:0] addr; logic busy; } a_t;
  typedef struct { int due; logic [7:0] idx; logic vld; } p_t;
  a_t qa[$];
  p_t qp[$];

  // Reference model: frame-latched placement plus an animation described only
  // by how many frame_starts have elapsed since the wobble began.
  int m_bx, m_by, m_k;
  bit m_show, m_active;

  task automatic model_reset();
    m_bx = 0; m_by = 0; m_show = 0; m_active = 0; m_k = 0;
  endtask

  function automatic int model_step();
    if (m_active && m_k < WOBBLE_FRAMES) return (m_k / HOLD) % 4;
    return 0;
  endfunction

  // One pixel cycle: predict, update the model, drive, advance one clock.
  task automatic cyc_drive(input bit fs, input bit ws, input int bx, input int by,
                           input bit show, input int dx, input int dy);
    bit hit;
    int addr;
    logic [7:0] rd;
    a_t ea;
    p_t ep;
    dx = dx & 1023;
    dy = dy & 1023;
    hit = m_show && dx >= m_bx && dx < m_bx + SW && dy >= m_by && dy < m_by + SH;
    addr = hit ? (model_step() * SW * SH + (dy - m_by) * SW + (dx - m_bx)) : 0;
    rd = rom_f(12'(addr));
    if (!m_active) begin
      if (ws) begin m_active = 1; m_k = 0; end
    end else if (fs) begin
      m_k++;
      if (m_k > WOBBLE_FRAMES) m_active = 0;
    end
    if (fs) begin m_bx = bx & 1023; m_by = by & 1023; m_show = show; end
    ea.due = cyc + 1; ea.addr = 12'(addr); ea.busy = m_active;
    ep.due = cyc + 2; ep.idx = hit ? rd : 8'h00; ep.vld = hit && (rd != 8'h00);
    qa.push_back(ea);
    qp.push_back(ep);
    frame_start = fs; wobble_start = ws;
    ball_x = 10'(bx); ball_y = 10'(by); ball_show = show;
    DrawX = 10'(dx); DrawY = 10'(dy);
    @(posedge Clk);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the queued predictions.
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (qa.size() > 0 && qa[0].due == cyc) begin
        a_t a;
        a = qa.pop_front();
        chk("rom_addr", 32'(rom_addr), 32'(a.addr));
        chk("busy", 32'(busy), 32'(a.busy));
      end
      if (qp.size() > 0 && qp[0].due == cyc) begin
        p_t p;
        p = qp.pop_front();
        chk("pal_index", 32'(pal_index), 32'(p.idx));
        chk("pal_valid", 32'(pal_valid), 32'(p.vld));
      end
    end
  end

  task automatic apply_reset();
    #2;
    Reset_n = 1'b0;
    #1;
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_pal_index", 32'(pal_index), 32'h0);
    chk("rst_pal_valid", 32'(pal_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    qa.delete();
    qp.delete();
    model_reset();
    frame_start = 0; wobble_start = 0; ball_show = 0;
    ball_x = 0; ball_y = 0; DrawX = 0; DrawY = 0;
    @(posedge Clk);
    @(posedge Clk);
    #6;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  int cbx = 100, cby = 50;
  bit cshow = 1;

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bit fs, ws;
      int dx, dy;
      fs = ($urandom_range(0, 5) == 0);
      ws = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) begin
        cbx = $urandom_range(0, 1023);
        cby = $urandom_range(0, 1023);
        cshow = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 3) != 0) begin
        dx = m_bx + int'($urandom_range(0, SW + 8)) - 4;
        dy = m_by + int'($urandom_range(0, SH + 8)) - 4;
      end else begin
        dx = $urandom_range(0, 1023);
        dy = $urandom_range(0, 1023);
      end
      cyc_drive(fs, ws, cbx, cby, cshow, dx, dy);
    end
  endtask

  initial begin
    int n;
    Reset_n = 1'b0;
    frame_start = 0; wobble_start = 0; ball_show = 0;
    ball_x = 0; ball_y = 0; DrawX = 0; DrawY = 0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_rom_addr", 32'(rom_addr), 32'h0);
    chk("reset_pal_index", 32'(pal_index), 32'h0);
    chk("reset_pal_valid", 32'(pal_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Directed placements: corners, transparent key, outside edges
    cyc_drive(0, 0, 100, 50, 1, 0, 0);
    cyc_drive(1, 0, 100, 50, 1, 0, 0);
    cyc_drive(0, 0, 100, 50, 1, 100, 50);
    cyc_drive(0, 0, 100, 50, 1, 131, 81);
    cyc_drive(0, 0, 100, 50, 1, 132, 81);
    cyc_drive(0, 0, 100, 50, 1, 105, 50);
    cyc_drive(0, 0, 100, 50, 1, 99, 50);
    cyc_drive(0, 0, 100, 50, 1, 100, 82);
    // Right edge near 1023 must not wrap; mid-frame ball_x change ignored
    cyc_drive(1, 0, 1000, 50, 1, 0, 0);
    cyc_drive(0, 0, 1000, 50, 1, 5, 60);
    cyc_drive(0, 0, 1000, 50, 1, 1023, 60);
    cyc_drive(0, 0, 200, 50, 1, 1010, 55);
    cyc_drive(0, 0, 200, 50, 1, 200, 55);
    cyc_drive(1, 0, 200, 50, 1, 210, 60);
    cyc_drive(0, 0, 200, 50, 1, 210, 60);

    random_cycles(400);

    // Full wobble run started together with a frame_start
    n = 0;
    while (m_active && n < 200) begin
      cyc_drive(1, 0, cbx, cby, 1, 0, 0);
      n++;
    end
    cbx = 300; cby = 200;
    cyc_drive(1, 1, cbx, cby, 1, 0, 0);
    n = 0;
    for (int f = 0; f < 300; f++) begin
      cyc_drive(0, (n == 40), cbx, cby, 1, cbx + 1 + (f % 30), cby + 1);
      cyc_drive(0, 0, cbx, cby, 1, cbx + 9, cby + (f % SH));
      cyc_drive(1, 0, cbx, cby, 1, cbx + 2, cby + 3);
      n++;
      if (busy == 1'b0) break;
    end
    chk("wobble_frame_count", 32'(n), 32'(WOBBLE_FRAMES + 1));

    // Reset in the middle of an animation with an opaque pixel in flight
    cyc_drive(1, 1, cbx, cby, 1, 0, 0);
    for (int f = 0; f < 20; f++) begin
      cyc_drive(0, 0, cbx, cby, 1, cbx + 4, cby + 4);
      cyc_drive(1, 0, cbx, cby, 1, cbx + 1, cby + 1);
    end
    cyc_drive(0, 0, cbx, cby, 1, cbx + 1, cby + 1);
    cyc_drive(0, 0, cbx, cby, 1, cbx + 1, cby + 1);
    chk("pre_reset_pal_valid", 32'(pal_valid), 32'h1);
    apply_reset();
    cyc_drive(0, 0, cbx, cby, 1, cbx + 1, cby + 1);
    cyc_drive(0, 0, 0, 0, 1, 1, 1);
    cyc_drive(1, 0, cbx, cby, 1, 0, 0);
    cyc_drive(0, 0, cbx, cby, 1, cbx + 1, cby + 1);
    cyc_drive(0, 0, cbx, cby, 1, cbx + 31, cby + 31);

    random_cycles(300);

    frame_start = 0; wobble_start = 0;
    repeat (4) @(posedge Clk);
    #1;
    chk("scoreboard_drained", 32'(qa.size() + qp.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
